// File: rtl/uart_keymap_pkg.sv
// Shared constants and receiver state encoding for the UART key decoder.
`timescale 1ns/1ps
package uart_keymap_pkg;

    localparam int unsigned MODE_TOGGLE = 0;
    localparam int unsigned MODE_PULSE  = 1;
    localparam int unsigned MODE_HOLD   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, framing-error detection.
`timescale 1ns/1ps
module uart_rx_core
    import uart_keymap_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned    CW        = $clog2(DIV);
    localparam logic [CW-1:0]  HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_core: CLK_FREQ/BAUD must be at least 4");
    end

    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_keymap_rx.sv
// Single UART receiver feeding a table of key codes; each slot drives one key_out bit.
`timescale 1ns/1ps
module uart_keymap_rx
    import uart_keymap_pkg::*;
#(
    parameter int unsigned            CLK_FREQ    = 50_000_000,
    parameter int unsigned            BAUD        = 9600,
    parameter int unsigned            NUM_KEYS    = 8,
    parameter logic [NUM_KEYS*8-1:0]  KEY_CODES   = "asdfzxcv",
    parameter int unsigned            MODE        = MODE_TOGGLE,
    parameter int unsigned            HOLD_CYCLES = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                frame_err
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);

    if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_keys_check
        $error("uart_keymap_rx: NUM_KEYS must be 1..32");
    end
    if (MODE > MODE_HOLD) begin : g_mode_check
        $error("uart_keymap_rx: MODE must be 0, 1 or 2");
    end
    if (MODE == MODE_HOLD && HOLD_CYCLES < 1) begin : g_hold_check
        $error("uart_keymap_rx: HOLD_CYCLES must be at least 1");
    end

    uart_rx_core #(
        .DIV (DIV)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_in   (uart_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
        logic hit;
        assign hit = rx_valid && (rx_data == KEY_CODES[i*8 +: 8]);

        if (MODE == MODE_HOLD) begin : g_hold
            logic [HW-1:0] hold_q;
            // A repeat hit reloads the counter, so the output never dips.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else if (hit) begin
                    hold_q <= HW'(HOLD_CYCLES);
                end else if (hold_q != '0) begin
                    hold_q <= hold_q - 1'b1;
                end
            end
            assign key_out[i] = (hold_q != '0);
        end else begin : g_latch
            logic key_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    key_q <= 1'b0;
                end else if (MODE == MODE_PULSE) begin
                    key_q <= hit;
                end else begin
                    key_q <= key_q ^ hit;
                end
            end
            assign key_out[i] = key_q;
        end
    end

endmodule

// File: tb/tb_uart_keymap_rx.sv
// Scoreboard bench: four decoders (toggle, pulse, two hold lengths) share one serial line.
`timescale 1ns/1ps
module tb_uart_keymap_rx;

    localparam int unsigned DIV = 16;
    localparam int unsigned ND  = 4;
    localparam logic [63:0] CODES = "asdfzxcv";
    localparam int unsigned MODES [ND] = '{0, 1, 2, 2};
    localparam int unsigned HOLDS [ND] = '{5, 5, 100, 300};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_in = 1'b1;

    logic [7:0] key_w   [ND];
    logic [7:0] data_w  [ND];
    logic       valid_w [ND];
    logic       ferr_w  [ND];

    int         n_cmp = 0;
    int         n_err = 0;
    longint     cyc = 0;
    logic [7:0] exp_bytes[$];
    int         rd_idx   [ND];
    int         ferr_cnt [ND];
    logic [7:0] exp_key  [ND];
    longint     last_t   [ND][8];
    int         exp_ferr = 0;
    logic [7:0] last_byte = 8'h00;

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        uart_keymap_rx #(
            .CLK_FREQ    (1_600_000),
            .BAUD        (100_000),
            .NUM_KEYS    (8),
            .KEY_CODES   (CODES),
            .MODE        (MODES[d]),
            .HOLD_CYCLES (HOLDS[d])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .uart_in   (uart_in),
            .key_out   (key_w[d]),
            .rx_data   (data_w[d]),
            .rx_valid  (valid_w[d]),
            .frame_err (ferr_w[d])
        );
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] hit_mask(logic [7:0] b);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (CODES[i*8 +: 8] == b) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit all_done();
        for (int d = 0; d < ND; d++) begin
            if (rd_idx[d] != exp_bytes.size()) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: pops expected bytes on rx_valid and tracks the key state each mode implies.
    initial begin : monitor
        logic [7:0] want;
        logic [7:0] b;
        logic [7:0] m;
        longint     age;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int d = 0; d < ND; d++) begin
                    rd_idx[d]   = 0;
                    ferr_cnt[d] = 0;
                    exp_key[d]  = '0;
                    for (int i = 0; i < 8; i++) last_t[d][i] = -1_000_000;
                end
            end else begin
                for (int d = 0; d < ND; d++) begin
                    if (MODES[d] == 2) begin
                        want = '0;
                        for (int i = 0; i < 8; i++) begin
                            age = cyc - last_t[d][i];
                            if (age >= 1 && age <= longint'(HOLDS[d])) want[i] = 1'b1;
                        end
                    end else begin
                        want = exp_key[d];
                    end
                    check($sformatf("key_out dut%0d cyc%0d", d, cyc), key_w[d], want);
                    if (MODES[d] == 1) exp_key[d] = '0;
                    if (ferr_w[d]) ferr_cnt[d]++;
                    if (valid_w[d]) begin
                        if (rd_idx[d] >= exp_bytes.size()) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL rx_valid dut%0d cyc%0d: strobe with rx_data 0x%0h, none expected",
                                     d, cyc, data_w[d]);
                        end else begin
                            b = exp_bytes[rd_idx[d]];
                            rd_idx[d]++;
                            check($sformatf("rx_data dut%0d cyc%0d", d, cyc), data_w[d], b);
                            m = hit_mask(b);
                            if (MODES[d] == 0) begin
                                exp_key[d] = exp_key[d] ^ m;
                            end else if (MODES[d] == 1) begin
                                exp_key[d] = m;
                            end else begin
                                for (int i = 0; i < 8; i++) if (m[i]) last_t[d][i] = cyc;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        if (stop_low_bits == 0) begin
            exp_bytes.push_back(b);
            last_byte = b;
        end else begin
            exp_ferr++;
        end
        uart_in = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_clks(DIV);
        end
        if (stop_low_bits != 0) begin
            uart_in = 1'b0;
            wait_clks(DIV * stop_low_bits);
        end
        uart_in = 1'b1;
        wait_clks(DIV);
    endtask

    task automatic checkpoint(input string tag);
        int budget;
        budget = 0;
        while (!all_done() && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        wait_clks(3);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s byte count dut%0d", tag, d), rd_idx[d], exp_bytes.size());
            check($sformatf("%s frame_err count dut%0d", tag, d), ferr_cnt[d], exp_ferr);
            check($sformatf("%s rx_data held dut%0d", tag, d), data_w[d], last_byte);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s key_out dut%0d", tag, d), key_w[d], 0);
            check($sformatf("%s rx_data dut%0d", tag, d), data_w[d], 0);
            check($sformatf("%s rx_valid dut%0d", tag, d), valid_w[d], 0);
            check($sformatf("%s frame_err dut%0d", tag, d), ferr_w[d], 0);
        end
    endtask

    initial begin : stimulus
        logic [7:0] b;
        int         idx;
        int         err;
        int         gap;

        wait_clks(4);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_clks(4);

        send_frame(8'h61, 0);
        wait_clks(4);
        #1;
        check("toggle after first 0x61", key_w[0], 8'h80);
        check("rx_data after first 0x61", data_w[0], 8'h61);
        send_frame(8'h61, 0);
        wait_clks(4);
        #1;
        check("toggle after second 0x61", key_w[0], 8'h00);
        checkpoint("toggle");

        send_frame(8'h76, 0);
        wait_clks(8);
        send_frame(8'h41, 0);
        wait_clks(4);
        #1;
        check("pulse idle after 0x76/0x41", key_w[1], 8'h00);
        checkpoint("pulse");

        send_frame(8'h73, 0);
        wait_clks(160);
        send_frame(8'h73, 0);
        send_frame(8'h73, 0);
        wait_clks(350);
        #1;
        check("hold100 expired", key_w[2], 8'h00);
        check("hold300 expired", key_w[3], 8'h00);
        checkpoint("hold");

        send_frame(8'h64, 40);
        wait_clks(2 * DIV);
        checkpoint("frame error");
        send_frame(8'h64, 0);
        checkpoint("after break");

        uart_in = 1'b0;
        wait_clks(4);
        uart_in = 1'b1;
        wait_clks(3 * DIV);
        checkpoint("glitch");
        send_frame(8'h7a, 0);
        send_frame(8'h78, 0);
        wait_clks(4);
        #1;
        // 0x76, three 0x73 and one good 0x64 toggled slots 0, 6, 5 before z/x.
        check("toggle after back-to-back 0x7a 0x78", key_w[0], 8'h6d);
        checkpoint("back-to-back");

        b = 8'h55;
        uart_in = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 3; i++) begin
            uart_in = b[i];
            wait_clks(DIV);
        end
        uart_in = b[3];
        wait_clks(DIV / 2);
        #2 rst_n = 1'b0;
        exp_bytes.delete();
        exp_ferr  = 0;
        last_byte = 8'h00;
        #1;
        check_reset_outputs("mid-frame reset");
        uart_in = 1'b1;
        wait_clks(8);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_clks(2 * DIV);
        send_frame(8'h63, 0);
        wait_clks(4);
        #1;
        check("toggle after reset and 0x63", key_w[0], 8'h02);
        checkpoint("post reset");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                idx = int'($urandom_range(7, 0));
                b = CODES[idx*8 +: 8];
            end else begin
                b = 8'($urandom);
            end
            err = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            send_frame(b, err);
            if (err != 0) gap = DIV;
            else if ($urandom_range(3, 0) == 0) gap = 0;
            else gap = int'($urandom_range(40, 1));
            wait_clks(gap);
        end
        checkpoint("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached before the stimulus completed");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_keymap_rx.md
Name: uart_keymap_rx

Overview:
- Generalised UART key decoder: one shared 8N1 receiver feeds a parametrised table of NUM_KEYS character codes, each driving one bit of key_out.
- Replaces per-key receivers (one UART core per key) with a single core plus a match/action stage.
- Adds per-design output mode (toggle / pulse / timed hold), a raw byte stream and framing-error reporting.
- Sits between the board UART RX pin and switch/button-style inputs of the processor I/O subsystem.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer, ≥4), checked by elaboration assertion.
- NUM_KEYS, 8, number of key slots / key_out width (1..32).
- KEY_CODES, {"asdfzxcv"}, NUM_KEYS*8 packed codes; slot i = KEY_CODES[i*8 +: 8], slot NUM_KEYS-1 in MSBs.
- MODE, 0, 0 = toggle, 1 = one-cycle pulse, 2 = timed hold.
- HOLD_CYCLES, 5_000_000, hold duration in clocks for MODE 2 (≥1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- uart_in, input, 1, asynchronous serial line, idle high.
- key_out, output, NUM_KEYS, per-key decoded state.
- rx_data, output, 8, last correctly framed byte.
- rx_valid, output, 1, one-cycle strobe: rx_data updated.
- frame_err, output, 1, one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (async assert, sync release): key_out=0, rx_data=0, rx_valid=0, frame_err=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- uart_in passes through a 2-flop synchroniser; all logic uses the synchronised signal (rxs).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs=0 -> START, baud counter cleared.
- START: at count DIV/2-1, rxs=0 -> DATA (count cleared, bit index 0); rxs=1 -> IDLE (glitch rejected, no strobe).
- DATA: sample rxs every DIV clocks, LSB first, 8 bits; after bit 7 -> STOP.
- STOP: after DIV clocks, sample rxs. 1 -> rx_data<=byte, rx_valid=1 next cycle, -> IDLE. 0 -> frame_err=1 next cycle, rx_data unchanged, no match action, -> BREAK.
- BREAK: wait until rxs=1, then -> IDLE. A held-low line gives exactly one frame_err.
- Key match: in the cycle rx_valid is high, every slot with code == rx_data acts (duplicate codes all act). key_out changes one cycle after rx_valid.
- MODE 0: key_out[i] inverts.
- MODE 1: key_out[i]=1 for exactly one cycle.
- MODE 2: key_out[i]=1; per-slot counter loads HOLD_CYCLES and decrements each clock; key_out[i] clears when it reaches 0. A repeat match reloads the counter (retrigger), and the output stays high continuously.
- Non-matching bytes still produce rx_valid; key_out is unaffected.
- Back-to-back frames (next start bit straight after the stop sample) are received with no byte loss.
- rst_n asserted mid-frame: immediate return to reset state, no strobe. The partial frame is discarded; a frame already in flight at release is resynchronised on the next falling edge.

Decomposition:
- Package uart_keymap_pkg: MODE_TOGGLE/MODE_PULSE/MODE_HOLD constants and the rx FSM state enum.
- Sub-module uart_rx_core (synchroniser + FSM + baud counter; outputs rx_data/rx_valid/frame_err).
- Top module: uart_rx_core plus a generate loop of per-slot match/action logic.

Test Plan (CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=16):
- Reset, then send 0x61 with default codes, MODE 0 -> rx_valid one pulse, rx_data=0x61, key_out=0x80; send 0x61 again -> key_out=0x00.
- MODE 1, send 0x76 -> key_out[0] high exactly one cycle, one cycle after rx_valid; send 0x41 -> rx_valid, key_out stays 0.
- MODE 2, HOLD_CYCLES=100, send 0x73 -> key_out[6] high 100 cycles then 0. Resend before expiry -> stays high 100 cycles after the second rx_valid.
- Frame 0x64 with stop bit driven low for 40 bit-times -> one frame_err, no rx_valid, rx_data unchanged; after line returns high, 0x64 is received normally.
- 4-clock low glitch on idle line -> no strobes, FSM back in IDLE. Frames 0x7a,0x78 back-to-back -> two rx_valid, MODE 0 key_out=0x0C.
- Assert rst_n during DATA bit 3 of a frame -> all outputs 0 immediately. After release, a new frame 0x63 is received correctly.
